mem_reg_wb_load: RTL and testbench
==================================

Name: mem_reg_wb_load

Overview:
MEM/WB pipeline register with an integrated load-path unit. It is the read-side counterpart of the EX/MEM store aligner.
- Issues word-aligned data-memory reads with a req/ack handshake.
- Extracts byte or halfword lanes from the returned word, then sign- or zero-extends them.
- Stalls the pipeline while memory is slow and aborts on timeout.
- Registers all write-back controls for the WB stage.

Parameters:
TIMEOUT, 15, number of WAIT cycles without Dmem_ack before the load is aborted (1..255).
CNT_W, 8, width of the wait counter.

Ports:
clk_MemWB  in  1  stage clock
rst_MemWB  in  1  synchronous, active-high reset
en_MemWB  in  1  stage enable; 0 holds all outputs and the FSM
valid_in_MemWB  in  1  0 inserts a bubble
Inst_in_MemWB  in  32  instruction
PC4_in_MemWB  in  32  PC+4
PC_imm_in_MemWB  in  32  PC+imm
Imm_in_MemWB  in  32  immediate
ALU_in_MemWB  in  32  ALU result, which is the load address
Rd_addr_in_MemWB  in  5  destination register
MemtoReg_in_MemWB  in  2  write-back select
RegWrite_in_MemWB  in  1  register-file write
MemRead_in_MemWB  in  1  instruction is a load
Byte_in_MemWB  in  1  byte access
Half_in_MemWB  in  1  halfword access
Sign_in_MemWB  in  1  1 = sign-extend, 0 = zero-extend
Dmem_rdata  in  32  memory read word
Dmem_ack  in  1  read data valid
Dmem_req  out  1  read request
Dmem_addr  out  32  {ALU_in_MemWB[31:2],2'b00}
stall_MemWB  out  1  freeze upstream stages
Load_data_out_MemWB  out  32  extended load data
ALU_out_MemWB, PC4_out_MemWB, PC_imm_out_MemWB, Imm_out_MemWB, Inst_out_MemWB  out  32  registered copies
Rd_addr_out_MemWB  out  5
MemtoReg_out_MemWB  out  2
RegWrite_out_MemWB  out  1
valid_out_MemWB  out  1
Bus_err_out_MemWB  out  1  load aborted by timeout

Behaviour:
- Reset (synchronous, priority over everything):
  - All outputs 0, except valid_out_MemWB=1.
  - Inst_out_MemWB=0.
  - FSM goes to IDLE; counter=0.
- Bubble: en_MemWB=1 and valid_in_MemWB=0.
  - All data/control outputs 0.
  - Inst_out_MemWB=32'h0000_0013; valid_out_MemWB=0.
  - No request is issued.
- en_MemWB=0: registers and FSM hold; Dmem_req=0; stall_MemWB=0.
- FSM states: IDLE, WAIT.
  - load_go = en & valid_in & MemRead_in.
  - Dmem_req = (IDLE & load_go) | WAIT.
  - stall_MemWB = Dmem_req & ~Dmem_ack & ~timeout.
- IDLE, non-load: register all inputs in one cycle; Load_data_out_MemWB=0.
- IDLE, load with Dmem_ack=1 in the same cycle: zero-wait. Register captures on that edge; no stall.
- IDLE, load with Dmem_ack=0: go to WAIT; counter=1.
  - Upstream holds its inputs stable while stall_MemWB=1.
  - Registers hold their previous values.
- WAIT with Dmem_ack=1: capture the instruction and the extracted data; go to IDLE; counter=0.
- WAIT with counter==TIMEOUT and no ack (timeout): abort.
  - Registers capture the instruction with RegWrite_out_MemWB=0 and Load_data_out_MemWB=0.
  - Bus_err_out_MemWB=1 for that instruction.
  - Go to IDLE.
  - Otherwise counter increments while in WAIT.
- Bus_err_out_MemWB is 0 for every other captured instruction.
- Extraction, with o=ALU_in[1:0]:
  - Byte: lane Dmem_rdata[8o+7:8o].
  - Half, o=0: [15:0]. o=1: [23:8]. o=2: [31:16].
  - Half, o=3: misaligned, see the optional feature.
  - Word (neither Byte nor Half): Dmem_rdata unchanged.
  - Extension: Sign=1 replicates the lane MSB; Sign=0 zero-fills.
  - Byte has priority over Half if both are set.
- Ack outside Dmem_req: ignored.
- Reset during WAIT: request drops in the same cycle; no capture.

Optional Feature:
MEM_MISALIGN_TRAP_EN
- Defined: adds output Misalign_out_MemWB (1 bit, reset 0).
  - A halfword load at o=3, or a word load with o!=0, issues no request.
  - It captures at once with RegWrite_out_MemWB=0, Load_data_out_MemWB=0 and Misalign_out_MemWB=1.
- Undefined: no trap.
  - Half at o=3 returns the raw Dmem_rdata.
  - Word with o!=0 returns the raw word from the aligned address.
  - This mirrors the store side's full-word default.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE=1'b0, WAIT=1'b1).
  - NOP constant 32'h0000_0013.
  - Lane offset constants.
- One natural sub-module, load_extract: purely combinational. Inputs are rdata, offset, Byte, Half and Sign; output is the 32-bit result.

Test Plan:
- Zero-wait lb, Sign=1, ALU=0x103, rdata=0x80_11_22_33, ack the same cycle -> next cycle Load_data=0xFFFF_FF80, stall never 1, Dmem_addr=0x100.
- lhu, ALU=0x2, rdata=0xBEEF_1234, ack after 3 cycles -> stall high exactly 3 cycles, then Load_data=0x0000_BEEF, RegWrite passed through.
- lw with no ack for TIMEOUT=15 cycles -> abort on the 15th WAIT cycle with Bus_err=1, RegWrite_out=0, Load_data=0; FSM back in IDLE.
- valid_in=0 -> Inst_out=0x00000013, valid_out=0, RegWrite_out=0; rst_MemWB=1 in WAIT -> Dmem_req=0 immediately, valid_out=1 after the edge.
- en=0 while a load is presented -> Dmem_req=0 and outputs frozen; raise en -> normal load completes.
- lh, ALU=0x7 -> with MEM_MISALIGN_TRAP_EN: Misalign=1, no request. Without it: Load_data equals the raw rdata.

Source files
------------

// File: rtl/mem_reg_wb_load_pkg.sv
// Shared definitions for the MEM/WB load-path stage: FSM encoding, NOP, lane offsets.
package mem_reg_wb_load_pkg;

    localparam logic [0:0]  ST_IDLE  = 1'b0;
    localparam logic [0:0]  ST_WAIT  = 1'b1;

    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    localparam logic [1:0]  LANE_0   = 2'd0;
    localparam logic [1:0]  LANE_1   = 2'd1;
    localparam logic [1:0]  LANE_2   = 2'd2;
    localparam logic [1:0]  LANE_3   = 2'd3;

    function automatic logic [31:0] ext8(input logic [7:0] b, input logic s);
        return {{24{s & b[7]}}, b};
    endfunction

    function automatic logic [31:0] ext16(input logic [15:0] h, input logic s);
        return {{16{s & h[15]}}, h};
    endfunction

endpackage

// File: rtl/mem_reg_wb_load_extract.sv
// Combinational lane extraction and sign/zero extension of a returned memory word.
module mem_reg_wb_load_extract
    import mem_reg_wb_load_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic        Byte,
    input  logic        Half,
    input  logic        Sign,
    output logic [31:0] result
);

    logic [7:0] byte_lane;

    always_comb begin
        byte_lane = rdata[7:0];
        case (offset)
            LANE_0:  byte_lane = rdata[7:0];
            LANE_1:  byte_lane = rdata[15:8];
            LANE_2:  byte_lane = rdata[23:16];
            default: byte_lane = rdata[31:24];
        endcase
    end

    always_comb begin
        result = rdata;
        if (Byte) begin
            result = ext8(byte_lane, Sign);
        end else if (Half) begin
            case (offset)
                LANE_0:  result = ext16(rdata[15:0], Sign);
                LANE_1:  result = ext16(rdata[23:8], Sign);
                LANE_2:  result = ext16(rdata[31:16], Sign);
                // a halfword straddling the word boundary comes back raw
                default: result = rdata;
            endcase
        end
    end

endmodule

// File: rtl/mem_reg_wb_load.sv
// MEM/WB pipeline register with req/ack load path, stall and timeout abort.
// Optional macro MEM_MISALIGN_TRAP_EN adds Misalign_out_MemWB and traps misaligned loads.
//
// state   | meaning
// IDLE    | no outstanding read; non-loads and zero-wait loads capture here
// WAIT    | read issued, holding Dmem_req until ack or timeout
module mem_reg_wb_load
    import mem_reg_wb_load_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 8
) (
    input  logic        clk_MemWB,
    input  logic        rst_MemWB,
    input  logic        en_MemWB,
    input  logic        valid_in_MemWB,
    input  logic [31:0] Inst_in_MemWB,
    input  logic [31:0] PC4_in_MemWB,
    input  logic [31:0] PC_imm_in_MemWB,
    input  logic [31:0] Imm_in_MemWB,
    input  logic [31:0] ALU_in_MemWB,
    input  logic [4:0]  Rd_addr_in_MemWB,
    input  logic [1:0]  MemtoReg_in_MemWB,
    input  logic        RegWrite_in_MemWB,
    input  logic        MemRead_in_MemWB,
    input  logic        Byte_in_MemWB,
    input  logic        Half_in_MemWB,
    input  logic        Sign_in_MemWB,
    input  logic [31:0] Dmem_rdata,
    input  logic        Dmem_ack,
    output logic        Dmem_req,
    output logic [31:0] Dmem_addr,
    output logic        stall_MemWB,
    output logic [31:0] Load_data_out_MemWB,
    output logic [31:0] ALU_out_MemWB,
    output logic [31:0] PC4_out_MemWB,
    output logic [31:0] PC_imm_out_MemWB,
    output logic [31:0] Imm_out_MemWB,
    output logic [31:0] Inst_out_MemWB,
    output logic [4:0]  Rd_addr_out_MemWB,
    output logic [1:0]  MemtoReg_out_MemWB,
    output logic        RegWrite_out_MemWB,
    output logic        valid_out_MemWB,
    output logic        Bus_err_out_MemWB
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic        Misalign_out_MemWB
`endif
);

    localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

    logic [0:0]       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       offset;
    logic [31:0]      ext_data, load_nxt;
    logic             load_go, req_go, misalign, timeout;
    logic             capture, bubble, regwrite_nxt, bus_err_nxt;

    assign offset = ALU_in_MemWB[1:0];

`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign = MemRead_in_MemWB & ~Byte_in_MemWB &
                      ((Half_in_MemWB & (offset == LANE_3)) |
                       (~Half_in_MemWB & (offset != LANE_0)));
`else
    assign misalign = 1'b0;
`endif

    assign load_go     = en_MemWB & valid_in_MemWB & MemRead_in_MemWB;
    assign req_go      = load_go & ~misalign;
    assign Dmem_req    = ~rst_MemWB & (((state == ST_IDLE) & req_go) |
                                       ((state == ST_WAIT) & en_MemWB));
    assign Dmem_addr   = {ALU_in_MemWB[31:2], 2'b00};
    assign timeout     = (state == ST_WAIT) & ~Dmem_ack & (cnt == TO_CNT);
    assign stall_MemWB = Dmem_req & ~Dmem_ack & ~timeout;

    mem_reg_wb_load_extract u_extract (
        .rdata  (Dmem_rdata),
        .offset (offset),
        .Byte   (Byte_in_MemWB),
        .Half   (Half_in_MemWB),
        .Sign   (Sign_in_MemWB),
        .result (ext_data)
    );

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        capture      = 1'b0;
        bubble       = 1'b0;
        load_nxt     = '0;
        regwrite_nxt = RegWrite_in_MemWB;
        bus_err_nxt  = 1'b0;
        if (state == ST_IDLE) begin
            if (!valid_in_MemWB) begin
                capture = 1'b1;
                bubble  = 1'b1;
            end else if (misalign) begin
                capture      = 1'b1;
                regwrite_nxt = 1'b0;
            end else if (MemRead_in_MemWB) begin
                if (Dmem_ack) begin
                    capture  = 1'b1;
                    load_nxt = ext_data;
                end else begin
                    state_nxt = ST_WAIT;
                    cnt_nxt   = CNT_W'(1);
                end
            end else begin
                capture = 1'b1;
            end
        end else begin
            if (Dmem_ack) begin
                capture   = 1'b1;
                load_nxt  = ext_data;
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end else if (cnt == TO_CNT) begin
                capture      = 1'b1;
                regwrite_nxt = 1'b0;
                bus_err_nxt  = 1'b1;
                state_nxt    = ST_IDLE;
                cnt_nxt      = '0;
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_MemWB) begin
        if (rst_MemWB) begin
            state               <= ST_IDLE;
            cnt                 <= '0;
            Load_data_out_MemWB <= '0;
            ALU_out_MemWB       <= '0;
            PC4_out_MemWB       <= '0;
            PC_imm_out_MemWB    <= '0;
            Imm_out_MemWB       <= '0;
            Inst_out_MemWB      <= '0;
            Rd_addr_out_MemWB   <= '0;
            MemtoReg_out_MemWB  <= '0;
            RegWrite_out_MemWB  <= 1'b0;
            valid_out_MemWB     <= 1'b1;
            Bus_err_out_MemWB   <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            Misalign_out_MemWB  <= 1'b0;
`endif
        end else if (en_MemWB) begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (capture) begin
                if (bubble) begin
                    Load_data_out_MemWB <= '0;
                    ALU_out_MemWB       <= '0;
                    PC4_out_MemWB       <= '0;
                    PC_imm_out_MemWB    <= '0;
                    Imm_out_MemWB       <= '0;
                    Inst_out_MemWB      <= INST_NOP;
                    Rd_addr_out_MemWB   <= '0;
                    MemtoReg_out_MemWB  <= '0;
                    RegWrite_out_MemWB  <= 1'b0;
                    valid_out_MemWB     <= 1'b0;
                    Bus_err_out_MemWB   <= 1'b0;
                end else begin
                    Load_data_out_MemWB <= load_nxt;
                    ALU_out_MemWB       <= ALU_in_MemWB;
                    PC4_out_MemWB       <= PC4_in_MemWB;
                    PC_imm_out_MemWB    <= PC_imm_in_MemWB;
                    Imm_out_MemWB       <= Imm_in_MemWB;
                    Inst_out_MemWB      <= Inst_in_MemWB;
                    Rd_addr_out_MemWB   <= Rd_addr_in_MemWB;
                    MemtoReg_out_MemWB  <= MemtoReg_in_MemWB;
                    RegWrite_out_MemWB  <= regwrite_nxt;
                    valid_out_MemWB     <= 1'b1;
                    Bus_err_out_MemWB   <= bus_err_nxt;
                end
`ifdef MEM_MISALIGN_TRAP_EN
                Misalign_out_MemWB <= ~bubble & misalign & (state == ST_IDLE);
`endif
            end
        end
    end

endmodule

// File: tb/tb_mem_reg_wb_load.sv
// Directed bench for mem_reg_wb_load: zero-wait, waited, timeout, bubble, enable and reset cases.
module tb_mem_reg_wb_load;

    logic        clk_MemWB = 1'b0;
    logic        rst_MemWB, en_MemWB, valid_in_MemWB;
    logic [31:0] Inst_in_MemWB, PC4_in_MemWB, PC_imm_in_MemWB, Imm_in_MemWB, ALU_in_MemWB;
    logic [4:0]  Rd_addr_in_MemWB;
    logic [1:0]  MemtoReg_in_MemWB;
    logic        RegWrite_in_MemWB, MemRead_in_MemWB, Byte_in_MemWB, Half_in_MemWB, Sign_in_MemWB;
    logic [31:0] Dmem_rdata;
    logic        Dmem_ack;
    logic        Dmem_req, stall_MemWB;
    logic [31:0] Dmem_addr, Load_data_out_MemWB, ALU_out_MemWB, PC4_out_MemWB;
    logic [31:0] PC_imm_out_MemWB, Imm_out_MemWB, Inst_out_MemWB;
    logic [4:0]  Rd_addr_out_MemWB;
    logic [1:0]  MemtoReg_out_MemWB;
    logic        RegWrite_out_MemWB, valid_out_MemWB, Bus_err_out_MemWB;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        Misalign_out_MemWB;
`endif

    int n_vec  = 0;
    int n_miss = 0;
    int stall_n;
    int cyc;

    always #5 clk_MemWB = ~clk_MemWB;

    mem_reg_wb_load #(.TIMEOUT(15), .CNT_W(8)) dut (
        .clk_MemWB           (clk_MemWB),
        .rst_MemWB           (rst_MemWB),
        .en_MemWB            (en_MemWB),
        .valid_in_MemWB      (valid_in_MemWB),
        .Inst_in_MemWB       (Inst_in_MemWB),
        .PC4_in_MemWB        (PC4_in_MemWB),
        .PC_imm_in_MemWB     (PC_imm_in_MemWB),
        .Imm_in_MemWB        (Imm_in_MemWB),
        .ALU_in_MemWB        (ALU_in_MemWB),
        .Rd_addr_in_MemWB    (Rd_addr_in_MemWB),
        .MemtoReg_in_MemWB   (MemtoReg_in_MemWB),
        .RegWrite_in_MemWB   (RegWrite_in_MemWB),
        .MemRead_in_MemWB    (MemRead_in_MemWB),
        .Byte_in_MemWB       (Byte_in_MemWB),
        .Half_in_MemWB       (Half_in_MemWB),
        .Sign_in_MemWB       (Sign_in_MemWB),
        .Dmem_rdata          (Dmem_rdata),
        .Dmem_ack            (Dmem_ack),
        .Dmem_req            (Dmem_req),
        .Dmem_addr           (Dmem_addr),
        .stall_MemWB         (stall_MemWB),
        .Load_data_out_MemWB (Load_data_out_MemWB),
        .ALU_out_MemWB       (ALU_out_MemWB),
        .PC4_out_MemWB       (PC4_out_MemWB),
        .PC_imm_out_MemWB    (PC_imm_out_MemWB),
        .Imm_out_MemWB       (Imm_out_MemWB),
        .Inst_out_MemWB      (Inst_out_MemWB),
        .Rd_addr_out_MemWB   (Rd_addr_out_MemWB),
        .MemtoReg_out_MemWB  (MemtoReg_out_MemWB),
        .RegWrite_out_MemWB  (RegWrite_out_MemWB),
        .valid_out_MemWB     (valid_out_MemWB),
        .Bus_err_out_MemWB   (Bus_err_out_MemWB)
`ifdef MEM_MISALIGN_TRAP_EN
        ,
        .Misalign_out_MemWB  (Misalign_out_MemWB)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_MemWB);
        #1;
    endtask

    // non-load defaults; individual steps override what they need
    task automatic idle_inputs();
        en_MemWB          = 1'b1;
        valid_in_MemWB    = 1'b1;
        Inst_in_MemWB     = 32'h0000_0033;
        PC4_in_MemWB      = 32'h0000_1004;
        PC_imm_in_MemWB   = 32'h0000_2000;
        Imm_in_MemWB      = 32'h0000_0010;
        ALU_in_MemWB      = 32'h0;
        Rd_addr_in_MemWB  = 5'd0;
        MemtoReg_in_MemWB = 2'b00;
        RegWrite_in_MemWB = 1'b0;
        MemRead_in_MemWB  = 1'b0;
        Byte_in_MemWB     = 1'b0;
        Half_in_MemWB     = 1'b0;
        Sign_in_MemWB     = 1'b0;
        Dmem_rdata        = 32'h0;
        Dmem_ack          = 1'b0;
    endtask

    initial begin
        rst_MemWB = 1'b1;
        idle_inputs();
        #1;
        chk("req_in_reset", 32'(Dmem_req), 32'h0);
        step();
        chk("rst_valid", 32'(valid_out_MemWB), 32'h1);
        chk("rst_inst", Inst_out_MemWB, 32'h0);
        chk("rst_regwrite", 32'(RegWrite_out_MemWB), 32'h0);
        chk("rst_load", Load_data_out_MemWB, 32'h0);
        chk("rst_buserr", 32'(Bus_err_out_MemWB), 32'h0);

        // zero-wait lb, sign-extended, lane 3
        rst_MemWB = 1'b0;
        Inst_in_MemWB = 32'h1030_0283; ALU_in_MemWB = 32'h103; Rd_addr_in_MemWB = 5'd5;
        MemtoReg_in_MemWB = 2'b01; RegWrite_in_MemWB = 1'b1; MemRead_in_MemWB = 1'b1;
        Byte_in_MemWB = 1'b1; Sign_in_MemWB = 1'b1;
        Dmem_rdata = 32'h8011_2233; Dmem_ack = 1'b1;
        #1;
        chk("lb_req", 32'(Dmem_req), 32'h1);
        chk("lb_addr", Dmem_addr, 32'h100);
        chk("lb_stall", 32'(stall_MemWB), 32'h0);
        step();
        chk("lb_data", Load_data_out_MemWB, 32'hFFFF_FF80);
        chk("lb_rd", 32'(Rd_addr_out_MemWB), 32'd5);
        chk("lb_regwrite", 32'(RegWrite_out_MemWB), 32'h1);
        chk("lb_inst", Inst_out_MemWB, 32'h1030_0283);

        // lhu at offset 2, ack on the fourth presented cycle
        Inst_in_MemWB = 32'h0021_5303; ALU_in_MemWB = 32'h2; Rd_addr_in_MemWB = 5'd6;
        Byte_in_MemWB = 1'b0; Half_in_MemWB = 1'b1; Sign_in_MemWB = 1'b0;
        Dmem_rdata = 32'hBEEF_1234;
        stall_n = 0;
        for (int c = 0; c < 4; c++) begin
            Dmem_ack = (c == 3);
            #1;
            if (stall_MemWB) stall_n++;
            if (c == 1) chk("lhu_hold", Load_data_out_MemWB, 32'hFFFF_FF80);
            step();
        end
        chk("lhu_stall_cycles", 32'(stall_n), 32'd3);
        chk("lhu_data", Load_data_out_MemWB, 32'h0000_BEEF);
        chk("lhu_regwrite", 32'(RegWrite_out_MemWB), 32'h1);
        chk("lhu_inst", Inst_out_MemWB, 32'h0021_5303);

        // lw that never gets acked: abort on the 15th WAIT cycle
        Inst_in_MemWB = 32'h0402_a383; ALU_in_MemWB = 32'h40; Rd_addr_in_MemWB = 5'd7;
        Half_in_MemWB = 1'b0; Dmem_ack = 1'b0; Dmem_rdata = 32'hDEAD_BEEF;
        stall_n = 0;
        cyc = 0;
        while (!Bus_err_out_MemWB && cyc < 40) begin
            #1;
            if (stall_MemWB) stall_n++;
            step();
            cyc++;
        end
        chk("to_cycles", 32'(cyc), 32'd16);
        chk("to_stall_cycles", 32'(stall_n), 32'd15);
        chk("to_buserr", 32'(Bus_err_out_MemWB), 32'h1);
        chk("to_regwrite", 32'(RegWrite_out_MemWB), 32'h0);
        chk("to_load", Load_data_out_MemWB, 32'h0);
        chk("to_rd", 32'(Rd_addr_out_MemWB), 32'd7);

        // back in IDLE: a plain ALU op captures in one cycle
        idle_inputs();
        ALU_in_MemWB = 32'h55; RegWrite_in_MemWB = 1'b1; Rd_addr_in_MemWB = 5'd9;
        #1;
        chk("alu_req", 32'(Dmem_req), 32'h0);
        chk("alu_stall", 32'(stall_MemWB), 32'h0);
        step();
        chk("alu_out", ALU_out_MemWB, 32'h55);
        chk("alu_buserr", 32'(Bus_err_out_MemWB), 32'h0);
        chk("alu_load", Load_data_out_MemWB, 32'h0);
        chk("alu_regwrite", 32'(RegWrite_out_MemWB), 32'h1);

        // bubble with a load presented
        valid_in_MemWB = 1'b0; MemRead_in_MemWB = 1'b1; Dmem_ack = 1'b1;
        #1;
        chk("bub_req", 32'(Dmem_req), 32'h0);
        step();
        chk("bub_inst", Inst_out_MemWB, 32'h0000_0013);
        chk("bub_valid", 32'(valid_out_MemWB), 32'h0);
        chk("bub_regwrite", 32'(RegWrite_out_MemWB), 32'h0);
        chk("bub_alu", ALU_out_MemWB, 32'h0);

        // reset while waiting drops the request immediately
        idle_inputs();
        MemRead_in_MemWB = 1'b1; ALU_in_MemWB = 32'h80; RegWrite_in_MemWB = 1'b1;
        step();
        chk("wait_req", 32'(Dmem_req), 32'h1);
        rst_MemWB = 1'b1;
        #1;
        chk("rstwait_req", 32'(Dmem_req), 32'h0);
        step();
        chk("rstwait_valid", 32'(valid_out_MemWB), 32'h1);
        chk("rstwait_inst", Inst_out_MemWB, 32'h0);
        rst_MemWB = 1'b0;

        // known state, then en=0 with a load presented and a stray ack
        idle_inputs();
        ALU_in_MemWB = 32'h77; Inst_in_MemWB = 32'h0000_0777;
        step();
        en_MemWB = 1'b0; MemRead_in_MemWB = 1'b1; Byte_in_MemWB = 1'b1;
        ALU_in_MemWB = 32'h201; Inst_in_MemWB = 32'h2010_4403; RegWrite_in_MemWB = 1'b1;
        Dmem_rdata = 32'h1234_F078; Dmem_ack = 1'b1;
        #1;
        chk("en0_req", 32'(Dmem_req), 32'h0);
        chk("en0_stall", 32'(stall_MemWB), 32'h0);
        step();
        chk("en0_alu_frozen", ALU_out_MemWB, 32'h77);
        chk("en0_inst_frozen", Inst_out_MemWB, 32'h0000_0777);
        en_MemWB = 1'b1;
        #1;
        chk("en1_req", 32'(Dmem_req), 32'h1);
        step();
        chk("lbu_data", Load_data_out_MemWB, 32'h0000_00F0);
        chk("lbu_inst", Inst_out_MemWB, 32'h2010_4403);

        // lh at offset 1, sign-extended, zero-wait
        idle_inputs();
        MemRead_in_MemWB = 1'b1; Half_in_MemWB = 1'b1; Sign_in_MemWB = 1'b1;
        ALU_in_MemWB = 32'h1; RegWrite_in_MemWB = 1'b1;
        Dmem_rdata = 32'h0080_0100; Dmem_ack = 1'b1;
        step();
        chk("lh1_data", Load_data_out_MemWB, 32'hFFFF_8001);

        // aligned lw
        Half_in_MemWB = 1'b0; ALU_in_MemWB = 32'h8; Dmem_rdata = 32'h1234_5678;
        step();
        chk("lw_data", Load_data_out_MemWB, 32'h1234_5678);

        // lh at offset 3
        Half_in_MemWB = 1'b1; ALU_in_MemWB = 32'h7; Dmem_rdata = 32'hCAFE_8001;
        Inst_in_MemWB = 32'h0070_9483;
        #1;
`ifdef MEM_MISALIGN_TRAP_EN
        chk("mis_req", 32'(Dmem_req), 32'h0);
        step();
        chk("mis_flag", 32'(Misalign_out_MemWB), 32'h1);
        chk("mis_regwrite", 32'(RegWrite_out_MemWB), 32'h0);
        chk("mis_load", Load_data_out_MemWB, 32'h0);
`else
        chk("mis_req", 32'(Dmem_req), 32'h1);
        step();
        chk("mis_raw", Load_data_out_MemWB, 32'hCAFE_8001);
        chk("mis_regwrite", 32'(RegWrite_out_MemWB), 32'h1);
`endif
        chk("mis_inst", Inst_out_MemWB, 32'h0070_9483);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
